// File: rtl/io_expander_pkg.sv
// Shared constants and the event-code layout used by the switch debouncer
// and its event FIFO.
package io_expander_pkg;
  localparam int SW_W        = 16;
  localparam int FIFO_DEPTH  = 4;
  localparam int EV_W        = 5;
  localparam int EV_EDGE_BIT = 4;
  localparam int EV_IDX_MSB  = 3;

  typedef logic [EV_W-1:0] ev_code_t;

  function automatic ev_code_t make_ev(input logic rise, input logic [EV_IDX_MSB:0] idx);
    ev_code_t ev;
    ev = '0;
    ev[EV_EDGE_BIT] = rise;
    ev[EV_IDX_MSB:0] = idx;
    return ev;
  endfunction
endpackage

// File: rtl/io_ev_fifo.sv
// 4-deep event FIFO. The head is shown combinationally from the storage
// registers and reads as zero while the FIFO is empty.
module io_ev_fifo
  import io_expander_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ev_code_t push_data,
  input  logic     pop,
  output ev_code_t head,
  output logic     full,
  output logic     empty,
  output logic [2:0] count
);
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  ev_code_t   mem [FIFO_DEPTH];
  logic       do_pop;
  logic       do_push;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/io_sw_debounce.sv
// 16-switch debouncer: sampled per-bit counters accept a level after
// STABLE_CNT equal samples; each accepted edge becomes a queued event.
module io_sw_debounce
  import io_expander_pkg::*;
#(
  parameter int SAMPLE_DIV = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW_W-1:0] sw_raw,
  output logic [SW_W-1:0] sw_stable,
  output logic            ev_valid,
  output logic [EV_W-1:0] ev_data,
  input  logic            ev_ack,
  output logic            ev_ovf
);
  localparam int PW = $clog2(SAMPLE_DIV + 1);

  logic [PW-1:0]   presc;
  logic            tick;
  logic [SW_W-1:0] sync1, sync2;
  logic [SW_W-1:0] diff, tog;
  logic [3:0]      cnt [SW_W];
  logic [SW_W-1:0] rise_pend, fall_pend, rise_nxt, fall_nxt, clr;
  logic            ovf_hit;
  logic            sel_found, sel_rise;
  logic [3:0]      sel_idx;
  logic            push, fifo_full, fifo_empty;
  logic [2:0]      fifo_count;

  assign tick = (presc == PW'(SAMPLE_DIV - 1));
  assign diff = sync2 ^ sw_stable;
  always_comb begin
    tog = '0;
    for (int i = 0; i < SW_W; i++)
      tog[i] = tick && diff[i] && (cnt[i] == 4'(STABLE_CNT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      sync1     <= '0;
      sync2     <= '0;
      sw_stable <= '0;
      for (int i = 0; i < SW_W; i++) cnt[i] <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      sync1 <= sw_raw;
      sync2 <= sync1;
      sw_stable <= sw_stable ^ tog;
      if (tick) begin
        for (int i = 0; i < SW_W; i++)
          cnt[i] <= (!diff[i] || tog[i]) ? 4'd0 : cnt[i] + 4'd1;
      end
    end
  end

  // Lowest pending index wins; at most one direction is pending per index.
  always_comb begin
    sel_found = 1'b0;
    sel_rise  = 1'b0;
    sel_idx   = '0;
    for (int i = SW_W - 1; i >= 0; i--) begin
      if (rise_pend[i] || fall_pend[i]) begin
        sel_found = 1'b1;
        sel_rise  = rise_pend[i];
        sel_idx   = 4'(i);
      end
    end
  end

  assign push = sel_found && (!fifo_full || (ev_ack && !fifo_empty));

  always_comb begin
    clr      = push ? (SW_W'(1) << sel_idx) : '0;
    rise_nxt = rise_pend & ~clr;
    fall_nxt = fall_pend & ~clr;
    ovf_hit  = 1'b0;
    for (int i = 0; i < SW_W; i++) begin
      if (tog[i]) begin
        if (!sw_stable[i]) begin
          if (fall_nxt[i]) ovf_hit = 1'b1;
          rise_nxt[i] = 1'b1;
          fall_nxt[i] = 1'b0;
        end else begin
          if (rise_nxt[i]) ovf_hit = 1'b1;
          fall_nxt[i] = 1'b1;
          rise_nxt[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_pend <= '0;
      fall_pend <= '0;
      ev_ovf    <= 1'b0;
    end else begin
      rise_pend <= rise_nxt;
      fall_pend <= fall_nxt;
      if (ovf_hit) ev_ovf <= 1'b1;
    end
  end

  // Handshake: ev_data is the head event whenever ev_valid=1; a cycle with
  // ev_valid=1 and ev_ack=1 consumes it. ev_ack with ev_valid=0 has no effect.
  io_ev_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (make_ev(sel_rise, sel_idx)),
    .pop       (ev_ack),
    .head      (ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign ev_valid = !fifo_empty;
endmodule

// File: tb/tb_io_sw_debounce.sv
// Directed bench for io_sw_debounce with a cycle-level reference model.
module tb_io_sw_debounce;
  localparam int SAMPLE_DIV = 10;
  localparam int STABLE_CNT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_raw;
  logic [15:0] sw_stable;
  logic        ev_valid;
  logic [4:0]  ev_data;
  logic        ev_ack;
  logic        ev_ovf;

  int n_checks = 0;
  int n_errors = 0;

  io_sw_debounce #(.SAMPLE_DIV(SAMPLE_DIV), .STABLE_CNT(STABLE_CNT)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .ev_ack    (ev_ack),
    .ev_ovf    (ev_ovf)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_cyc;
  logic [15:0] m_stable, m_h0, m_h1, m_rise, m_fall;
  int          m_run [16];
  logic        m_ovf;
  logic [4:0]  exp_q [$];

  task automatic m_reset();
    m_cyc = 0; m_stable = '0; m_h0 = '0; m_h1 = '0;
    m_rise = '0; m_fall = '0; m_ovf = 1'b0;
    for (int i = 0; i < 16; i++) m_run[i] = 0;
    exp_q.delete();
  endtask

  task automatic m_step();
    logic        pop, push, tick;
    logic [15:0] samp;
    logic [4:0]  code;
    int          sel;
    pop = ev_ack && (exp_q.size() > 0);
    sel = -1;
    for (int i = 0; i < 16; i++)
      if (sel < 0 && (m_rise[i] || m_fall[i])) sel = i;
    push = (sel >= 0) && (exp_q.size() < 4 || pop);
    code = '0;
    if (push) code = {m_rise[sel], 4'(sel)};
    samp = m_h1; m_h1 = m_h0; m_h0 = sw_raw;
    m_cyc++;
    tick = (m_cyc % SAMPLE_DIV) == 0;
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      exp_q.push_back(code);
      m_rise[sel] = 1'b0; m_fall[sel] = 1'b0;
    end
    if (tick) begin
      for (int i = 0; i < 16; i++) begin
        if (samp[i] != m_stable[i]) begin
          m_run[i]++;
          if (m_run[i] == STABLE_CNT) begin
            m_run[i] = 0;
            if (!m_stable[i]) begin
              if (m_fall[i]) m_ovf = 1'b1;
              m_rise[i] = 1'b1; m_fall[i] = 1'b0;
            end else begin
              if (m_rise[i]) m_ovf = 1'b1;
              m_fall[i] = 1'b1; m_rise[i] = 1'b0;
            end
            m_stable[i] = ~m_stable[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) m_reset();
    else m_step();
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #3;
    check("cyc_sw_stable", 32'(sw_stable), 32'(m_stable));
    check("cyc_ev_valid", 32'(ev_valid), 32'(exp_q.size() > 0));
    check("cyc_ev_data", 32'(ev_data), 32'((exp_q.size() > 0) ? exp_q[0] : 5'h00));
    check("cyc_ev_ovf", 32'(ev_ovf), 32'(m_ovf));
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_bit(input int idx, input logic val, input string name);
    int n;
    n = 0;
    while (sw_stable[idx] !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sw_stable[idx]), 32'(val));
  endtask

  task automatic ack_once();
    ev_ack = 1'b1;
    @(negedge clk);
    ev_ack = 1'b0;
  endtask

  logic [4:0] exp4 [5];
  logic [4:0] e;

  initial begin
    rst = 1'b1; sw_raw = '0; ev_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sw_stable", 32'(sw_stable), 32'h0);
    check("rst_ev_valid", 32'(ev_valid), 32'h0);
    check("rst_ev_data", 32'(ev_data), 32'h0);
    check("rst_ev_ovf", 32'(ev_ovf), 32'h0);
    rst = 1'b0;

    // single rise on bit 3
    repeat (5) @(negedge clk);
    sw_raw[3] = 1'b1;
    wait_bit(3, 1'b1, "t1_stable3");
    check("t1_valid_not_yet", 32'(ev_valid), 32'h0);
    @(negedge clk);
    check("t1_ev_valid", 32'(ev_valid), 32'h1);
    check("t1_ev_data", 32'(ev_data), 32'h13);
    ack_once();
    check("t1_drained", 32'(ev_valid), 32'h0);

    // 2-tick glitch on bit 7 must be rejected
    sw_raw[7] = 1'b1;
    repeat (20) @(negedge clk);
    sw_raw[7] = 1'b0;
    repeat (60) @(negedge clk);
    check("t2_stable", 32'(sw_stable), 32'h0008);
    check("t2_no_event", 32'(ev_valid), 32'h0);

    // all 16 rise; FIFO fills, rest wait pending, then drain in order
    do_reset();
    sw_raw = 16'hFFFF;
    repeat (60) @(negedge clk);
    check("t3_stable", 32'(sw_stable), 32'hFFFF);
    check("t3_count_full", 32'(dut.u_fifo.count), 32'h4);
    check("t3_ovf", 32'(ev_ovf), 32'h0);
    for (int i = 0; i < 16; i++) begin
      e = 5'(16 + i);
      check("t3_valid", 32'(ev_valid), 32'h1);
      check("t3_order", 32'(ev_data), 32'(e));
      ack_once();
      if (i == 0) check("t3_push_pop_full", 32'(dut.u_fifo.count), 32'h4);
    end
    check("t3_empty", 32'(ev_valid), 32'h0);

    // bit 2 rise then fall while FIFO stays full -> overwrite + ovf
    do_reset();
    sw_raw = 16'h00F0;
    repeat (60) @(negedge clk);
    sw_raw = 16'h00F4;
    wait_bit(2, 1'b1, "t4_rise2");
    check("t4_no_ovf_yet", 32'(ev_ovf), 32'h0);
    sw_raw = 16'h00F0;
    wait_bit(2, 1'b0, "t4_fall2");
    @(negedge clk);
    check("t4_ovf", 32'(ev_ovf), 32'h1);
    exp4[0] = 5'h14; exp4[1] = 5'h15; exp4[2] = 5'h16; exp4[3] = 5'h17; exp4[4] = 5'h02;
    for (int i = 0; i < 5; i++) begin
      check("t4_order", 32'(ev_data), 32'(exp4[i]));
      ack_once();
    end
    check("t4_empty", 32'(ev_valid), 32'h0);
    check("t4_ovf_sticky", 32'(ev_ovf), 32'h1);

    // reset mid-count, then rises reported again after 4 ticks
    do_reset();
    sw_raw = 16'hFFFF;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_async_stable", 32'(sw_stable), 32'h0);
    check("t6_async_valid", 32'(ev_valid), 32'h0);
    check("t6_async_ovf", 32'(ev_ovf), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (39) @(negedge clk);
    check("t6_before_tick4", 32'(sw_stable), 32'h0);
    @(negedge clk);
    check("t6_at_tick4", 32'(sw_stable), 32'hFFFF);
    @(negedge clk);
    check("t6_first_event", 32'(ev_data), 32'h10);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
